// File: rtl/seconds_event_tx.sv
// seconds_event_tx: transmit side of the event-link time distribution.
// On each valid PPS edge it offers the seconds-marker event, waits a fixed
// delay, then serializes the seconds value for the following second as 32
// shift events (MSB first) through a valid/ready handshake with the arbiter.
module seconds_event_tx #(
  parameter logic [7:0]  EVENT_SHIFT_0        = 8'h70,
  parameter logic [7:0]  EVENT_SHIFT_1        = 8'h71,
  parameter logic [7:0]  EVENT_SECONDS_MARKER = 8'h7D,
  parameter int unsigned START_DELAY          = 1000,
  parameter int unsigned EVENT_GAP            = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ppsToggle,
  input  logic        secondsValid,
  input  logic [31:0] secondsNext,
  input  logic        overrunClear,
  output logic [7:0]  eventCode,
  output logic        eventValid,
  input  logic        eventReady,
  output logic [31:0] status
);

  localparam int unsigned GAP_W = (EVENT_GAP > 1) ? $clog2(EVENT_GAP) : 1;

  typedef enum logic [2:0] {
    IDLE,
    MARKER,
    DELAY,
    SHIFT,
    GAP
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic               ppsToggleD;
  logic               ppsEdge;
  logic               accept;
  logic [15:0]        delayCnt;
  logic [GAP_W-1:0]   gapCnt;
  logic [31:0]        shiftReg;
  logic [4:0]         bitIdx;
  logic               overrun;
  logic [15:0]        seqCount;

  logic               loadDelay;
  logic               loadShift;
  logic               advanceBit;
  logic               loadGap;
  logic               incCount;
  logic               setOverrun;

  // Only edges seen while the seconds value is trustworthy start a sequence.
  assign ppsEdge = secondsValid & (ppsToggle ^ ppsToggleD);
  assign accept  = eventValid & eventReady;

  assign status = {(state != IDLE), overrun, 14'd0, seqCount};

  // PPS toggle delay; reset loads the live level so no false edge follows reset.
  always_ff @(posedge clk) begin
    ppsToggleD <= ppsToggle;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode and datapath control strobes.
  // An edge in DELAY/SHIFT/GAP takes priority over any accept in the same
  // cycle, so an aborted sequence never advances or completes.
  always_comb begin
    stateNext  = state;
    loadDelay  = 1'b0;
    loadShift  = 1'b0;
    advanceBit = 1'b0;
    loadGap    = 1'b0;
    incCount   = 1'b0;
    setOverrun = 1'b0;
    case (state)
      IDLE: begin
        if (ppsEdge) begin
          stateNext = MARKER;
        end
      end
      MARKER: begin
        // The pending marker already announces this second; just flag it.
        if (ppsEdge) begin
          setOverrun = 1'b1;
        end
        if (accept) begin
          stateNext = DELAY;
          loadDelay = 1'b1;
        end
      end
      DELAY: begin
        if (ppsEdge) begin
          stateNext  = MARKER;
          setOverrun = 1'b1;
        end else if (delayCnt == 16'd0) begin
          stateNext = SHIFT;
          loadShift = 1'b1;
        end
      end
      SHIFT: begin
        if (ppsEdge) begin
          stateNext  = MARKER;
          setOverrun = 1'b1;
        end else if (accept) begin
          if (bitIdx == 5'd0) begin
            stateNext = IDLE;
            incCount  = 1'b1;
          end else begin
            advanceBit = 1'b1;
            if (EVENT_GAP > 0) begin
              stateNext = GAP;
              loadGap   = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (ppsEdge) begin
          stateNext  = MARKER;
          setOverrun = 1'b1;
        end else if (gapCnt == '0) begin
          stateNext = SHIFT;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Event presentation: decoded from state so valid/code hold until accepted.
  always_comb begin
    eventValid = 1'b0;
    eventCode  = 8'h00;
    case (state)
      MARKER: begin
        eventValid = 1'b1;
        eventCode  = EVENT_SECONDS_MARKER;
      end
      SHIFT: begin
        eventValid = 1'b1;
        eventCode  = shiftReg[31] ? EVENT_SHIFT_1 : EVENT_SHIFT_0;
      end
      default: begin
        eventValid = 1'b0;
        eventCode  = 8'h00;
      end
    endcase
  end

  // Start-delay countdown after marker acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      delayCnt <= '0;
    end else if (loadDelay) begin
      delayCnt <= 16'(START_DELAY - 1);
    end else if (state == DELAY && delayCnt != 16'd0) begin
      delayCnt <= delayCnt - 16'd1;
    end
  end

  // Inter-event idle countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      gapCnt <= '0;
    end else if (loadGap) begin
      gapCnt <= GAP_W'(EVENT_GAP - 1);
    end else if (state == GAP && gapCnt != '0) begin
      gapCnt <= gapCnt - GAP_W'(1);
    end
  end

  // Seconds shift register: captured only when leaving DELAY, MSB presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg <= '0;
      bitIdx   <= '0;
    end else if (loadShift) begin
      shiftReg <= secondsNext;
      bitIdx   <= 5'd31;
    end else if (advanceBit) begin
      shiftReg <= {shiftReg[30:0], 1'b0};
      bitIdx   <= bitIdx - 5'd1;
    end
  end

  // Sticky overrun (set beats clear) and completed-sequence counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun  <= 1'b0;
      seqCount <= '0;
    end else begin
      if (setOverrun) begin
        overrun <= 1'b1;
      end else if (overrunClear) begin
        overrun <= 1'b0;
      end
      if (incCount) begin
        seqCount <= seqCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seconds_event_tx.sv
// Testbench for seconds_event_tx: randomized values and backpressure checked
// against an event-list/timing model derived from the sequence rules.
module tb_seconds_event_tx;

  localparam int unsigned SD = 8;
  localparam int unsigned G  = 4;
  localparam logic [7:0]  S0 = 8'h70;
  localparam logic [7:0]  S1 = 8'h71;
  localparam logic [7:0]  MK = 8'h7D;

  logic        clk = 1'b0;
  logic        reset;
  logic        ppsToggle;
  logic        secondsValid;
  logic [31:0] secondsNext;
  logic        overrunClear;
  logic [7:0]  eventCode;
  logic        eventValid;
  logic        eventReady = 1'b0;
  logic [31:0] status;

  seconds_event_tx #(
    .EVENT_SHIFT_0(S0),
    .EVENT_SHIFT_1(S1),
    .EVENT_SECONDS_MARKER(MK),
    .START_DELAY(SD),
    .EVENT_GAP(G)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ppsToggle(ppsToggle),
    .secondsValid(secondsValid),
    .secondsNext(secondsNext),
    .overrunClear(overrunClear),
    .eventCode(eventCode),
    .eventValid(eventValid),
    .eventReady(eventReady),
    .status(status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int modelCount = 0;
  int readyMode = 0;   // 0 always ready, 1 random, 2 targeted holds, 3 never
  int bpBase = 0;
  int stBase = 0;

  // Accepted events as the arbiter sees them.
  logic [7:0] accCode[$];
  int         accCyc[$];
  int         accRise[$];
  int         validSeen = 0;
  int         stableErr = 0;
  int         curRise = 0;
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic [7:0] prevCode = 8'h00;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor on the falling edge: record accepts, rise times and stability.
  always @(negedge clk) begin
    if (eventValid === 1'b1) validSeen++;
    if (eventValid === 1'b1 && (!prevValid || prevReady)) curRise = cyc;
    if (prevValid && !prevReady && !(eventValid === 1'b1 && eventCode === prevCode)) stableErr++;
    if (eventValid === 1'b1 && eventReady === 1'b1) begin
      accCode.push_back(eventCode);
      accCyc.push_back(cyc);
      accRise.push_back(curRise);
    end
    prevValid = (eventValid === 1'b1);
    prevReady = (eventReady === 1'b1);
    prevCode  = eventCode;
  end

  // Arbiter-side ready generation.
  initial begin
    int hold0;
    int hold1;
    int n;
    hold0 = 0;
    hold1 = 0;
    forever begin
      @(posedge clk);
      #1;
      n = accCode.size() - bpBase;
      case (readyMode)
        0: eventReady = 1'b1;
        1: eventReady = ($urandom_range(0, 3) != 0);
        2: begin
          if (eventValid && n == 0 && hold0 < 10) begin
            eventReady = 1'b0;
            hold0++;
          end else if (eventValid && n == 6 && hold1 < 10) begin
            eventReady = 1'b0;
            hold1++;
          end else begin
            eventReady = 1'b1;
          end
        end
        default: eventReady = 1'b0;
      endcase
      if (readyMode != 2) begin
        hold0 = 0;
        hold1 = 0;
      end
    end
  end

  task automatic startSeq(output int base, output int tog);
    base = accCode.size();
    stBase = stableErr;
    tog = cyc;
    ppsToggle = ~ppsToggle;
  endtask

  // Present val only while the sequence sits in its start delay.
  task automatic waitAccepts(input int target, input logic [31:0] val, input int base);
    for (int i = 0; i < 3000 && accCode.size() < target; i++) begin
      if (accCode.size() == base + 1) secondsNext = val;
      else if (accCode.size() > base + 1) secondsNext = $urandom;
      step();
    end
  endtask

  task automatic finishSeq(input logic [31:0] val, input int base, input bit lat, input int tog);
    logic [7:0] exp;
    int want;
    waitAccepts(base + 33, val, base);
    checkEq("seqLen", accCode.size(), base + 33);
    for (int k = 0; k < 33; k++) begin
      if (base + k < accCode.size()) begin
        exp = (k == 0) ? MK : (val[32 - k] ? S1 : S0);
        checkEq("code", {24'd0, accCode[base + k]}, {24'd0, exp});
      end
    end
    if (lat && base < accCode.size()) checkEq("markerLat", accRise[base], tog + 1);
    for (int k = 1; k < 33; k++) begin
      if (base + k < accCode.size()) begin
        want = (k == 1) ? int'(SD) + 1 : int'(G) + 1;
        checkEq("spacing", accRise[base + k] - accCyc[base + k - 1], want);
      end
    end
    step();
    checkEq("busyEnd", {31'd0, status[31]}, 32'd0);
    checkEq("count", {16'd0, status[15:0]}, modelCount);
    checkEq("stable", stableErr - stBase, 0);
    repeat (5) step();
    checkEq("noExtra", accCode.size(), base + 33);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int tog;
    int vs;
    logic [31:0] v;
    reset = 1'b1;
    ppsToggle = 1'b1;
    secondsValid = 1'b1;
    overrunClear = 1'b0;
    secondsNext = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    checkEq("rstValid", {31'd0, eventValid}, 32'd0);
    checkEq("rstCode", {24'd0, eventCode}, 32'd0);
    checkEq("rstStatus", status, 32'd0);
    vs = validSeen;
    repeat (5) step();
    checkEq("noFalseEdge", validSeen - vs, 0);

    // Normal sequence with the reference value.
    readyMode = 0;
    secondsNext = $urandom;
    startSeq(base, tog);
    step();
    checkEq("busyMarker", {31'd0, status[31]}, 32'd1);
    checkEq("zeroBits", {18'd0, status[29:16]}, 32'd0);
    modelCount++;
    finishSeq(32'hE5A30001, base, 1'b1, tog);

    // Backpressure on the marker and on bit 5.
    bpBase = accCode.size();
    readyMode = 2;
    v = $urandom;
    startSeq(base, tog);
    modelCount++;
    finishSeq(v, base, 1'b1, tog);
    if (base + 6 < accCode.size()) begin
      checkEq("holdMarker", accCyc[base] - accRise[base], 10);
      checkEq("holdBit5", accCyc[base + 6] - accRise[base + 6], 10);
    end
    readyMode = 0;

    // Edges while the seconds value is untrusted are ignored.
    secondsValid = 1'b0;
    vs = validSeen;
    for (int i = 0; i < 3; i++) begin
      ppsToggle = ~ppsToggle;
      repeat (20) step();
    end
    checkEq("notValidEvents", validSeen - vs, 0);
    checkEq("notValidCount", {16'd0, status[15:0]}, modelCount);
    secondsValid = 1'b1;
    step();

    // Random values with random backpressure; first one drops secondsValid mid-run.
    for (int r = 0; r < 4; r++) begin
      readyMode = 1;
      v = $urandom;
      secondsNext = $urandom;
      startSeq(base, tog);
      if (r == 0) begin
        step();
        secondsValid = 1'b0;
      end
      modelCount++;
      finishSeq(v, base, 1'b1, tog);
      secondsValid = 1'b1;
    end
    readyMode = 0;

    // Overrun: second edge after marker + 10 shifts.
    v = $urandom;
    startSeq(base, tog);
    waitAccepts(base + 11, v, base);
    checkEq("preAbort", accCode.size(), base + 11);
    tog = cyc;
    ppsToggle = ~ppsToggle;
    secondsNext = $urandom;
    step();
    checkEq("overrunSet", {31'd0, status[30]}, 32'd1);
    checkEq("abortMarker", {23'd0, eventValid, eventCode}, {23'd0, 1'b1, MK});
    checkEq("abortCount", {16'd0, status[15:0]}, modelCount);
    v = $urandom;
    stBase = stableErr;
    modelCount++;
    finishSeq(v, base + 11, 1'b1, tog);
    overrunClear = 1'b1;
    step();
    overrunClear = 1'b0;
    checkEq("overrunClr", {31'd0, status[30]}, 32'd0);

    // Edge in MARKER together with overrunClear: set wins, one marker only.
    readyMode = 3;
    v = $urandom;
    startSeq(base, tog);
    step();
    ppsToggle = ~ppsToggle;
    overrunClear = 1'b1;
    step();
    overrunClear = 1'b0;
    checkEq("simulOverrun", {31'd0, status[30]}, 32'd1);
    checkEq("simulMarker", {23'd0, eventValid, eventCode}, {23'd0, 1'b1, MK});
    readyMode = 0;
    modelCount++;
    finishSeq(v, base, 1'b0, tog);

    // Reset while a shift event is pending.
    v = $urandom;
    startSeq(base, tog);
    waitAccepts(base + 3, v, base);
    readyMode = 3;
    for (int i = 0; i < 10 && eventValid !== 1'b1; i++) step();
    checkEq("shiftPending", {31'd0, eventValid}, 32'd1);
    reset = 1'b1;
    step();
    checkEq("midRstValid", {31'd0, eventValid}, 32'd0);
    checkEq("midRstCode", {24'd0, eventCode}, 32'd0);
    checkEq("midRstStatus", status, 32'd0);
    reset = 1'b0;
    modelCount = 0;
    readyMode = 0;
    step();
    v = $urandom;
    secondsNext = $urandom;
    startSeq(base, tog);
    modelCount++;
    finishSeq(v, base, 1'b1, tog);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seconds_event_tx.md
# seconds_event_tx

Transmit side of the event-link time distribution. On each PPS edge from the NTP clock it emits the seconds-marker event, then serializes the 32-bit seconds value for the following second as 32 shift events (MSB first). Receivers therefore hold the complete value before the next marker makes it current. The block sits between the NTP clock block and the event-code arbiter, and talks to the arbiter through a valid/ready handshake.

## Interface
- `EVENT_SHIFT_0`, default 8'h70: event code sent for a 0 bit.
- `EVENT_SHIFT_1`, default 8'h71: event code sent for a 1 bit.
- `EVENT_SECONDS_MARKER`, default 8'h7D: seconds-marker event code.
- `START_DELAY`, default 1000: clocks from marker acceptance to the first shift event. Range 1..65535.
- `EVENT_GAP`, default 4: idle clocks after each accepted shift event. 0 allowed.

Ports:
- `clk` input 1: sole clock.
- `reset` input 1: synchronous, active-high reset.
- `ppsToggle` input 1: toggles once per valid PPS; synchronous to `clk`.
- `secondsValid` input 1: seconds value is trustworthy.
- `secondsNext` input 32: NTP seconds for the next second.
- `overrunClear` input 1: single-cycle clear of the sticky overrun flag.
- `eventCode` output 8: event code offered to the arbiter.
- `eventValid` output 1: `eventCode` is valid.
- `eventReady` input 1: arbiter accepts when high together with `eventValid`.
- `status` output 32: bit31 busy (state ≠ IDLE), bit30 sticky overrun, bits 29:16 zero, bits 15:0 completed-sequence count (wraps).

## Operation
- PPS edge:
  - `ppsToggleD` is a one-clock delay of `ppsToggle`.
  - edge = `ppsToggle != ppsToggleD`.
  - The edge is ignored when `secondsValid` is 0.
- States:
  - IDLE: on edge, go to MARKER.
  - MARKER: present `EVENT_SECONDS_MARKER`. On accept, load the delay counter with `START_DELAY-1` and go to DELAY.
  - DELAY: count down. At 0, latch `secondsNext` into the shift register, set bit index to 31, and go to SHIFT.
  - SHIFT: present `EVENT_SHIFT_1` or `EVENT_SHIFT_0` for the current bit. On accept:
    - bit 0 accepted: increment the sequence count and go to IDLE.
    - else if `EVENT_GAP > 0`: go to GAP.
    - else: stay in SHIFT with the next bit.
  - GAP: `eventValid` is low. After `EVENT_GAP` clocks, go to SHIFT with the next bit.
- Handshake:
  - Once `eventValid` is high, it and `eventCode` stay constant until accepted.
  - Acceptance = `eventValid & eventReady` on a rising edge.
  - There is never more than one outstanding event.
- Edge while in DELAY, SHIFT or GAP:
  - The sequence is aborted and the remaining bits are dropped. Any unaccepted shift event is withdrawn.
  - Overrun is set and the state goes to MARKER. The count is not incremented.
  - A withdrawn shift event never has `eventValid` high in the cycle after the edge.
- Edge while in MARKER: the pending marker is kept and overrun is set. No second marker is sent.
- `secondsValid` falling mid-sequence does not abort; the sequence completes.
- Overrun and `overrunClear` in the same cycle: set wins.
- `secondsNext` is sampled only when leaving DELAY.

## Timing
- Reset values:
  - `eventValid` = 0, `eventCode` = 8'h00.
  - state IDLE; overrun = 0; count = 0.
  - `ppsToggleD` loads from `ppsToggle`, so no false edge occurs after reset.
- Edge detected in cycle N (IDLE): `eventValid` = 1 with the marker code at N+1.
- Marker accepted at cycle M: the first shift event is valid at M+`START_DELAY`+1.
- Shift accepted at cycle K: the next shift event is valid at K+`EVENT_GAP`+1. With gap 0 it is valid at K+1.
- A minimum sequence with `eventReady` tied high takes 1 + `START_DELAY` + 32 + 31·`EVENT_GAP` clocks.
- Reset asserted mid-operation: outputs take their reset values on the next clock edge. No partial event is re-offered.

## Test plan
- Normal sequence:
  - Stimulus: `secondsValid`=1, `secondsNext`=32'hE5A30001, `eventReady`=1, `START_DELAY`=8, `EVENT_GAP`=4, one toggle.
  - Response: 0x7D, then 0x71,0x71,0x71,0x70,0x70,0x71,0x70,0x71,… ending 0x70…0x70,0x71.
  - 33 events total; first shift 9 clocks after marker acceptance; shifts 5 clocks apart; count = 1; busy falls after the last accept.
- Backpressure:
  - Stimulus: hold `eventReady`=0 for 10 cycles on the marker and on bit 5.
  - Response: `eventValid`/`eventCode` stable throughout; no duplicate or lost event; 33 events total.
- Not valid: `secondsValid`=0, three toggles -> `eventValid` never asserted; count stays 0.
- Overrun:
  - Stimulus: second toggle after 10 shift events accepted.
  - Response: overrun = 1; next event 0x7D; then 32 fresh shifts of the new `secondsNext`; count = 1.
  - Then pulse `overrunClear` -> bit30 = 0.
- Reset: assert `reset` during SHIFT with `eventValid`=1 -> next cycle `eventValid`=0, `eventCode`=0, status = 0; the next toggle starts a clean sequence.
- Simultaneous events: toggle in MARKER together with `overrunClear` -> overrun = 1; exactly one marker is sent.
